// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : edge_event_arbiter
// Description : Per-channel rising/falling edge detection with a one-deep
//               pending slot per channel. Pending events are serialised
//               round-robin onto one registered valid/ready event port.
//               The optional input synchroniser is enabled by defining
//               EDGE_ARB_SYNC_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    sig,
    input  logic [N-1:0]    rise_en,
    input  logic [N-1:0]    fall_en,
    output logic            evt_valid,
    input  logic            evt_ready,
    output logic [ID_W-1:0] evt_id,
    output logic            evt_rise,
    output logic [N-1:0]    ovf,
    input  logic            ovf_clr
);

    logic [N-1:0]    w_sig;
    logic            w_primed;
    logic [N-1:0]    r_sig_dly;
    logic [N-1:0]    r_pend;
    logic [N-1:0]    r_pend_rise;
    logic [ID_W-1:0] r_last;

    logic [N-1:0]    w_rise;
    logic [N-1:0]    w_fall;
    logic            w_load;
    logic            w_gnt_found;
    logic [ID_W-1:0] w_gnt_idx;
    logic [ID_W-1:0] w_scan_idx;
    logic [N-1:0]    w_gnt_vec;
    logic [N-1:0]    w_pend_nxt;
    logic [N-1:0]    w_pend_rise_nxt;
    logic [N-1:0]    w_ovf_set;

`ifdef EDGE_ARB_SYNC_EN
    logic [N-1:0] r_sync1;
    logic [N-1:0] r_sync2;
    logic [1:0]   r_prime_cnt;

    // Priming waits out the synchroniser fill so reset zeros never look like edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_prime_cnt <= 2'd0;
        end else begin
            r_sync1 <= sig;
            r_sync2 <= r_sync1;
            if (r_prime_cnt != 2'd3) begin
                r_prime_cnt <= r_prime_cnt + 2'd1;
            end
        end
    end

    assign w_sig    = r_sync2;
    assign w_primed = (r_prime_cnt == 2'd3);
`else
    logic r_primed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_primed <= 1'b0;
        end else begin
            r_primed <= 1'b1;
        end
    end

    assign w_sig    = sig;
    assign w_primed = r_primed;
`endif

    assign w_rise = w_sig & ~r_sig_dly & rise_en & {N{w_primed}};
    assign w_fall = ~w_sig & r_sig_dly & fall_en & {N{w_primed}};
    assign w_load = !evt_valid || evt_ready;

    // Round-robin search starting just after the last granted channel.
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_idx   = '0;
        w_scan_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_scan_idx = ID_W'((int'(r_last) + k) % N);
            if (!w_gnt_found && r_pend[w_scan_idx]) begin
                w_gnt_found = 1'b1;
                w_gnt_idx   = w_scan_idx;
            end
        end
    end

    assign w_gnt_vec = (w_load && w_gnt_found) ? (N'(1) << w_gnt_idx) : '0;

    // A fresh edge may refill the slot that is being granted this cycle.
    always_comb begin
        w_pend_nxt      = r_pend & ~w_gnt_vec;
        w_pend_rise_nxt = r_pend_rise;
        w_ovf_set       = '0;
        for (int i = 0; i < N; i++) begin
            if (w_rise[i] || w_fall[i]) begin
                if (!r_pend[i] || w_gnt_vec[i]) begin
                    w_pend_nxt[i]      = 1'b1;
                    w_pend_rise_nxt[i] = w_rise[i];
                end else begin
                    w_ovf_set[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_dly   <= '0;
            r_pend      <= '0;
            r_pend_rise <= '0;
            r_last      <= '0;
            evt_valid   <= 1'b0;
            evt_id      <= '0;
            evt_rise    <= 1'b0;
            ovf         <= '0;
        end else begin
            r_sig_dly   <= w_sig;
            r_pend      <= w_pend_nxt;
            r_pend_rise <= w_pend_rise_nxt;
            ovf         <= (ovf & ~{N{ovf_clr}}) | w_ovf_set;
            if (w_load) begin
                if (w_gnt_found) begin
                    evt_valid <= 1'b1;
                    evt_id    <= w_gnt_idx;
                    evt_rise  <= r_pend_rise[w_gnt_idx];
                    r_last    <= w_gnt_idx;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_edge_event_arbiter
// Description : Directed bench for edge_event_arbiter with a behavioural
//               reference model compared every cycle plus literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    localparam int N    = 4;
    localparam int ID_W = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    sig;
    logic [N-1:0]    rise_en;
    logic [N-1:0]    fall_en;
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;
    logic            evt_rise;
    logic [N-1:0]    ovf;
    logic            ovf_clr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_valid  = 1'b0;
    int           m_id     = 0;
    bit           m_rise   = 1'b0;
    logic [N-1:0] m_ovf    = '0;
    bit           m_pend   [N];
    bit           m_prise  [N];
    logic [N-1:0] m_prev   = '0;
    bit           m_primed = 1'b0;
    int           m_last   = 0;

    edge_event_arbiter #(
        .N    (N),
        .ID_W (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig       (sig),
        .rise_en   (rise_en),
        .fall_en   (fall_en),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_rise  (evt_rise),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_id     = 0;
        m_rise   = 1'b0;
        m_ovf    = '0;
        m_prev   = '0;
        m_primed = 1'b0;
        m_last   = 0;
        for (int i = 0; i < N; i++) begin
            m_pend[i]  = 1'b0;
            m_prise[i] = 1'b0;
        end
    endtask

    task automatic model_step();
        int g;
        bit r;
        bit f;
        g = -1;
        if (!m_valid || evt_ready) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && m_pend[(m_last + k) % N]) g = (m_last + k) % N;
            end
            if (g >= 0) begin
                m_valid   = 1'b1;
                m_id      = g;
                m_rise    = m_prise[g];
                m_pend[g] = 1'b0;
                m_last    = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (ovf_clr) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            r = m_primed && sig[i] && !m_prev[i] && rise_en[i];
            f = m_primed && !sig[i] && m_prev[i] && fall_en[i];
            if (r || f) begin
                if (!m_pend[i]) begin
                    m_pend[i]  = 1'b1;
                    m_prise[i] = r;
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
        m_prev   = sig;
        m_primed = 1'b1;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("evt_valid", 32'(evt_valid), 32'(m_valid));
            chk("evt_id",    32'(evt_id),    32'(m_id));
            chk("evt_rise",  32'(evt_rise),  32'(m_rise));
            chk("ovf",       32'(ovf),       32'(m_ovf));
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic lit_evt(input string name, input bit v, input int id, input bit rs);
        chk({name, ".valid"}, 32'(evt_valid), 32'(v));
        if (v) begin
            chk({name, ".id"},   32'(evt_id),   32'(id));
            chk({name, ".rise"}, 32'(evt_rise), 32'(rs));
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        sig       = 4'b1111;
        rise_en   = 4'b1111;
        fall_en   = 4'b0000;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;
        tick(3);
        lit_evt("reset", 1'b0, 0, 1'b0);
        chk("reset.ovf", 32'(ovf), 32'h0);
        chk("reset.id",  32'(evt_id), 32'h0);

        // Priming: sig already high at release must not produce an event
        rst_n = 1'b1;
        tick(4);
        lit_evt("priming", 1'b0, 0, 1'b0);

        // Single rising edge on channel 0
        rise_en = 4'b0001;
        sig     = 4'b0000;
        tick(2);
        sig = 4'b0001;
        tick(1);
        lit_evt("single.t", 1'b0, 0, 1'b0);
        tick(1);
        lit_evt("single.t1", 1'b1, 0, 1'b1);
        tick(1);
        lit_evt("single.t2", 1'b0, 0, 1'b0);

        // Simultaneous rising edges drain round-robin from last+1
        rise_en = 4'b1111;
        sig     = 4'b0000;
        tick(1);
        sig = 4'b1111;
        tick(2);
        lit_evt("rr0", 1'b1, 1, 1'b1);
        tick(1);
        lit_evt("rr1", 1'b1, 2, 1'b1);
        tick(1);
        lit_evt("rr2", 1'b1, 3, 1'b1);
        tick(1);
        lit_evt("rr3", 1'b1, 0, 1'b1);
        tick(1);
        lit_evt("rr.end", 1'b0, 0, 1'b0);

        // Backpressure and overflow on channel 2
        rise_en   = 4'b0000;
        fall_en   = 4'b0100;
        evt_ready = 1'b0;
        sig       = 4'b1011;
        tick(2);
        lit_evt("bp.fall", 1'b1, 2, 1'b0);
        rise_en = 4'b0100;
        sig     = 4'b1111;
        tick(1);
        lit_evt("bp.hold", 1'b1, 2, 1'b0);
        chk("bp.ovf0", 32'(ovf), 32'h0);
        sig = 4'b1011;
        tick(1);
        lit_evt("bp.hold2", 1'b1, 2, 1'b0);
        chk("bp.ovf", 32'(ovf), 32'h4);
        evt_ready = 1'b1;
        tick(1);
        lit_evt("bp.rise", 1'b1, 2, 1'b1);
        tick(1);
        lit_evt("bp.end", 1'b0, 0, 1'b0);
        chk("bp.ovf.sticky", 32'(ovf), 32'h4);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(ovf), 32'h0);

        // Grant on channel 1 coincides with a new falling edge on channel 1
        rise_en = 4'b0000;
        fall_en = 4'b0000;
        sig     = 4'b1001;
        tick(1);
        rise_en = 4'b0010;
        fall_en = 4'b0010;
        sig     = 4'b1011;
        tick(1);
        sig = 4'b1001;
        tick(1);
        lit_evt("same.gnt", 1'b1, 1, 1'b1);
        chk("same.ovf", 32'(ovf), 32'h0);
        tick(1);
        lit_evt("same.next", 1'b1, 1, 1'b0);
        tick(1);
        lit_evt("same.end", 1'b0, 0, 1'b0);
        chk("same.ovf2", 32'(ovf), 32'h0);

        // Reset while an event is presented and three more are pending
        evt_ready = 1'b0;
        rise_en   = 4'b1111;
        fall_en   = 4'b0000;
        sig       = 4'b0000;
        tick(1);
        sig = 4'b1111;
        tick(2);
        lit_evt("mid.pre", 1'b1, 2, 1'b1);
        rst_n = 1'b0;
        #1;
        lit_evt("mid.rst", 1'b0, 0, 1'b0);
        chk("mid.rst.id",   32'(evt_id),   32'h0);
        chk("mid.rst.rise", 32'(evt_rise), 32'h0);
        chk("mid.rst.ovf",  32'(ovf),      32'h0);
        evt_ready = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(5);
        lit_evt("mid.quiet", 1'b0, 0, 1'b0);
        sig = 4'b1110;
        tick(1);
        sig = 4'b1111;
        tick(2);
        lit_evt("mid.new", 1'b1, 0, 1'b1);
        tick(1);
        lit_evt("mid.end", 1'b0, 0, 1'b0);

        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel edge-event scheduler that detects rising and/or falling edges on N input signals, queues one pending event per channel, and serializes them onto a single valid/ready event port by round-robin arbitration. It sits between raw per-channel edge sources and a single downstream consumer, such as an interrupt controller or event FIFO. That consumer takes one event per handshake, so simultaneous edges on different channels are never lost.

## Interface
- `N`, 4: number of input channels (2..32)
- `ID_W`, 2: width of channel index, must satisfy 2**ID_W >= N

- `clk` input 1: single clock; all logic on posedge
- `rst_n` input 1: asynchronous active-low reset
- `sig` input N: monitored signals, synchronous to `clk` unless `EDGE_ARB_SYNC_EN` is defined
- `rise_en` input N: per-channel rising-edge enable
- `fall_en` input N: per-channel falling-edge enable
- `evt_valid` output 1: event available
- `evt_ready` input 1: consumer accepts the event when high with `evt_valid`
- `evt_id` output ID_W: channel index of the presented event
- `evt_rise` output 1: 1 = rising edge, 0 = falling edge
- `ovf` output N: sticky per-channel overflow flags
- `ovf_clr` input 1: synchronous clear of all `ovf` bits

## Operation
- **Reset values:** every output resets to 0, including `evt_valid`, `evt_id`, `evt_rise` and `ovf`. `sig_dly`, `pend`, `pend_rise` and the RR pointer (`last`) also reset to 0. `primed` resets to 0.
- **Edge detection:** `rise[i] = sig[i] & ~sig_dly[i] & rise_en[i] & primed`. `fall[i] = ~sig[i] & sig_dly[i] & fall_en[i] & primed`.
- **Priming:** `primed` goes to 1 on the first clock after reset deasserts. No edges are reported on that first cycle, even if `sig` is high.
- **Both edges in one cycle:** a channel can raise at most one of `rise` or `fall` per cycle.
- **Pending set:** an edge on channel i with `pend[i]=0` sets `pend[i]=1` and `pend_rise[i]=rise[i]`.
- **Pending collision:** an edge on channel i with `pend[i]=1` that is not being granted this cycle sets `ovf[i]=1`. The stored event is kept and the new edge is dropped.
- **Load condition:** the output slot loads when `!evt_valid || evt_ready`.
- **Grant selection:** on load, the grant goes to the first channel with `pend=1`, searching from `last+1` upward and wrapping modulo N. The pointer `last` then takes the granted index.
- **On grant:** `evt_valid=1`, `evt_id=idx`, `evt_rise=pend_rise[idx]`, and `pend[idx]` clears.
- **No pending on load:** if nothing is pending, `evt_valid` goes to 0 and `evt_id`/`evt_rise` hold their values.
- **Edge on the granted channel:** a new edge on the channel granted in the same cycle re-sets `pend` with the new type. This is not an overflow.
- **Stall:** while `evt_valid=1 && evt_ready=0`, `evt_valid`, `evt_id` and `evt_rise` hold stable.
- **Overflow clear:** `ovf_clr` clears all `ovf` bits. A same-cycle overflow set on a channel wins over the clear for that channel.
- **Disabling a channel:** clearing `rise_en`/`fall_en` suppresses new events on that channel. It does not clear an already-pending event.
- **Reset mid-operation:** asserting `rst_n` low immediately clears all state, including a presented but unaccepted event. `primed` is re-armed.

## Timing
- **Edge latency:** an edge seen at posedge t (sig new, `sig_dly` old) sets `pend` at t. `evt_valid` rises at t+1 at the earliest, giving 1 cycle from detection to presentation.
- **Throughput:** with `evt_ready` held high, one event is delivered per cycle.
- **Output registration:** `evt_valid`, `evt_id`, `evt_rise` and `ovf` are all registered. There is no combinational path from `evt_ready` to any output.
- **Worst-case service:** N simultaneous edges drain in N consecutive cycles with `evt_ready=1`. Each channel waits at most N grants.

## Configuration
- **`EDGE_ARB_SYNC_EN` defined:** `sig` passes through a 2-flop synchronizer (reset 0) per channel before edge detection. This adds 2 cycles of latency, and `primed` asserts after 3 cycles so that synchronizer fill cannot create false edges.
- **`EDGE_ARB_SYNC_EN` not defined:** `sig` feeds `sig_dly` and the edge logic directly, and the timing above applies unchanged.

## Test plan
- **Reset priming:** drive `sig=4'b1111` and `rise_en=4'b1111` through reset, then release. Required: `evt_valid` stays 0, because there are no edges while unprimed.
- **Single rising edge:** `rise_en=4'b0001`, `sig[0]` 0->1 at cycle t, `evt_ready=1`. Required: at t+1, `evt_valid=1`, `evt_id=0`, `evt_rise=1`; at t+2, `evt_valid=0`.
- **Simultaneous edges with round-robin:** all channels enabled for rise, `sig` 0->4'b1111 in one cycle, `evt_ready=1`. Required: `evt_id` sequence 1,2,3,0 (`last` starts at 0), then `evt_valid=0`.
- **Backpressure and overflow:** `fall_en[2]=1`, `evt_ready=0`. Drive `sig[2]` 1->0, then 0->1 with `rise_en[2]=1`, then 1->0. Required: the first fall is held on the port; the second event goes to pending; the third sets `ovf[2]=1`. After `evt_ready=1`, deliver ids 2 (fall) then 2 (rise). Then pulse `ovf_clr` and check `ovf=0`.
- **Grant with same-channel edge:** pend[1] is granted in the same cycle a new falling edge arrives on channel 1. Required: `ovf[1]` stays 0, and the next event is id 1 with `evt_rise=0`.
- **Reset mid-stream:** assert `rst_n` low while `evt_valid=1` and 3 events are pending. Required: all outputs are 0 immediately, with no events after release until new edges arrive past priming.
